// File: rtl/qr_pkg.sv
// Shared definitions for the covariance / QR datapath: element format, row packing
// and the accumulator-to-element saturation used by both stages.
package qr_pkg;

    localparam int unsigned DW    = 16;  // element width, signed Q8.8
    localparam int unsigned FRAC  = 8;   // fractional bits per element
    localparam int unsigned NE    = 4;   // elements per row / vector
    localparam int unsigned ROW_W = 64;  // packed row width (NE * DW)
    localparam int unsigned NPAIR = 10;  // unique entries of a symmetric NE x NE matrix

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StScale,
        StDone
    } cov_state_e;

    // LSB position of element i within a packed row
    function automatic int unsigned elem_lo(input int unsigned i);
        return i * DW;
    endfunction

    // Index of the upper-triangle entry shared by (i,j) and (j,i)
    function automatic int unsigned pair_idx(input int unsigned i, input int unsigned j);
        int unsigned lo;
        int unsigned hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * NE - (lo * (lo - 1)) / 2 + (hi - lo);
    endfunction

    // Clamp a sign-extended accumulator value to the signed 16-bit range
    function automatic logic [DW-1:0] sat16(input logic signed [63:0] v);
        if (v > 64'sd32767) begin
            return 16'h7fff;
        end else if (v < -64'sd32768) begin
            return 16'h8000;
        end else begin
            return v[DW-1:0];
        end
    endfunction

endpackage

// File: rtl/cov_mac.sv
// One covariance entry: signed DW x DW multiply accumulated into an ACC_W register.
module cov_mac
    import qr_pkg::*;
#(
    parameter int unsigned ACC_W = 40
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [DW-1:0]    a,
    input  logic signed [DW-1:0]    b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] acc_q;

    assign prod = a * b;
    assign acc  = acc_q;

    // Clear has priority so a new run never inherits a stale sum
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/covariance_accumulator.sv
// Sample covariance C = (1/N) * sum(x * x^T) over 2^N_LOG2 four-element vectors,
// delivered as four packed rows with a one-cycle done pulse.
module covariance_accumulator
    import qr_pkg::*;
#(
    parameter int unsigned N_LOG2 = 4,
    parameter int unsigned ACC_W  = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             x_valid,
    input  logic [ROW_W-1:0] x_in,
    output logic             x_ready,
    output logic [ROW_W-1:0] A0,
    output logic [ROW_W-1:0] A1,
    output logic [ROW_W-1:0] A2,
    output logic [ROW_W-1:0] A3,
    output logic             busy,
    output logic             done
);

    localparam int unsigned N     = 1 << N_LOG2;
    localparam int unsigned SHIFT = FRAC + N_LOG2;

    cov_state_e state_q, state_d;
    logic [N_LOG2:0] cnt_q, cnt_d;
    logic            clr;
    logic            accept;

    logic signed [ACC_W-1:0] acc [NPAIR];
    logic [DW-1:0]           res [NPAIR];
    logic [NE-1:0][ROW_W-1:0] row_d;
    logic [NE-1:0][ROW_W-1:0] a_q;

    // Next-state, counter and MAC control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr     = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    clr     = 1'b1;
                    cnt_d   = '0;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (x_valid) begin
                    accept = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == (N_LOG2 + 1)'(N - 1)) begin
                        state_d = StScale;
                    end
                end
            end
            StScale: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and sample-counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign x_ready = (state_q == StAccum);
    assign busy    = (state_q == StAccum) || (state_q == StScale);
    assign done    = (state_q == StDone);

    // Upper-triangle MACs only; the lower triangle reuses them below
    for (genvar i = 0; i < NE; i++) begin : g_row
        for (genvar j = i; j < NE; j++) begin : g_col
            cov_mac #(
                .ACC_W(ACC_W)
            ) u_mac (
                .clk  (clk),
                .reset(reset),
                .clr  (clr),
                .en   (accept),
                .a    (x_in[elem_lo(i) +: DW]),
                .b    (x_in[elem_lo(j) +: DW]),
                .acc  (acc[pair_idx(i, j)])
            );
        end
    end

    for (genvar p = 0; p < NPAIR; p++) begin : g_res
        assign res[p] = sat16(64'(acc[p] >>> SHIFT));
    end

    for (genvar r = 0; r < NE; r++) begin : g_pack_r
        for (genvar c = 0; c < NE; c++) begin : g_pack_c
            assign row_d[r][elem_lo(c) +: DW] = res[pair_idx(r, c)];
        end
    end

    // Result rows are captured only in SCALE and held otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
        end else if (state_q == StScale) begin
            a_q <= row_d;
        end
    end

    assign A0 = a_q[0];
    assign A1 = a_q[1];
    assign A2 = a_q[2];
    assign A3 = a_q[3];

endmodule

// File: tb/tb_covariance_accumulator.sv
// Randomised scoreboard bench for covariance_accumulator.
module tb_covariance_accumulator;

    typedef logic [3:0][63:0] mat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        x_valid = 1'b0;
    logic [63:0] x_in = '0;
    logic        x_ready;
    logic [63:0] A0, A1, A2, A3;
    logic        busy;
    logic        done;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = -100;
    int   n_done = 0;
    bit   pend_busy = 1'b0;
    mat_t sb [$];
    mat_t last_exp;
    logic [63:0] v [16];

    covariance_accumulator dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .x_valid(x_valid),
        .x_in   (x_in),
        .x_ready(x_ready),
        .A0     (A0),
        .A1     (A1),
        .A2     (A2),
        .A3     (A3),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: full matrix from plain integer sums, floor-divided by 2^12, clamped
    function automatic mat_t model(input logic [63:0] vv [16]);
        mat_t   m;
        longint s;
        logic [15:0] e;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                s = 0;
                for (int n = 0; n < 16; n++) begin
                    s += longint'($signed(vv[n][16*r +: 16])) * longint'($signed(vv[n][16*c +: 16]));
                end
                s = s >>> 12;
                if (s > 32767) e = 16'h7fff;
                else if (s < -32768) e = 16'h8000;
                else e = s[15:0];
                m[r][16*c +: 16] = e;
            end
        end
        return m;
    endfunction

    // Monitor: compares every done against the oldest expected result
    always @(negedge clk) begin
        mat_t exp;
        if (reset) begin
            pend_busy = 1'b0;
        end else begin
            if (pend_busy) begin
                chk("busy_after_done", 64'(busy), 64'd0);
                pend_busy = 1'b0;
            end
            if (x_valid && x_ready) last_acc = cyc;
            if (done) begin
                n_done++;
                chk("done_latency", 64'(cyc), 64'(last_acc + 2));
                chk("busy_in_done", 64'(busy), 64'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(n_done), 64'(-1));
                end else begin
                    exp = sb.pop_front();
                    chk("row0", A0, exp[0]);
                    chk("row1", A1, exp[1]);
                    chk("row2", A2, exp[2]);
                    chk("row3", A3, exp[3]);
                end
                pend_busy = 1'b1;
            end
        end
    end

    // Issue start, then feed cnt samples; optional gaps, mid-run start, start+valid in IDLE
    task automatic feed(input logic [63:0] vv [16], input int cnt, input bit gaps,
                        input bit midstart, input bit junk);
        int  idx;
        bit  vld;
        bit  sent;
        sent = 1'b0;
        start   = 1'b1;
        x_valid = junk;
        x_in    = junk ? {$urandom, $urandom} : 64'd0;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        while (idx < cnt) begin
            vld = gaps ? 1'($urandom_range(1)) : 1'b1;
            start = (midstart && idx >= 5 && !sent);
            if (start) sent = 1'b1;
            x_valid = vld;
            x_in    = vld ? vv[idx] : {$urandom, $urandom};
            @(posedge clk);
            if (vld) idx++;
            #1;
        end
        start   = 1'b0;
        x_valid = 1'b0;
    endtask

    task automatic run(input logic [63:0] vv [16], input bit gaps, input bit midstart,
                       input bit junk);
        last_exp = model(vv);
        sb.push_back(last_exp);
        feed(vv, 16, gaps, midstart, junk);
        for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
        #1;
        chk("done_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_A0", A0, 64'd0);
        chk("rst_A3", A3, 64'd0);
        chk("rst_ready", 64'(x_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);

        for (int n = 0; n < 16; n++) v[n] = 64'h0000_0000_0000_0100;
        run(v, 1'b0, 1'b0, 1'b0);
        chk("fixed_e0_A0", last_exp[0], 64'h0000_0000_0000_0100);

        for (int n = 0; n < 16; n++) v[n] = 64'h0100_0100_0100_0100;
        run(v, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 16; n++)
            v[n] = n[0] ? 64'h0000_0000_0100_fe00 : 64'h0000_0000_0100_0200;
        run(v, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 16; n++) v[n] = 64'h7fff_7fff_7fff_7fff;
        run(v, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 16; n++) v[n] = 64'h0000_0000_8000_7fff;
        run(v, 1'b0, 1'b0, 1'b0);

        // Same random vectors, gap-free then gapped with stray starts
        for (int n = 0; n < 16; n++) v[n] = {$urandom, $urandom};
        run(v, 1'b0, 1'b0, 1'b0);
        run(v, 1'b1, 1'b1, 1'b1);

        // Abort after 7 accepted samples
        for (int n = 0; n < 16; n++) v[n] = 64'h7fff_7fff_7fff_7fff;
        feed(v, 7, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_A0", A0, 64'd0);
        chk("abort_A1", A1, 64'd0);
        chk("abort_A2", A2, 64'd0);
        chk("abort_A3", A3, 64'd0);
        chk("abort_ready", 64'(x_ready), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);

        for (int n = 0; n < 16; n++) v[n] = {$urandom, $urandom};
        run(v, 1'b1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("hold_A0", A0, last_exp[0]);
        chk("hold_A3", A3, last_exp[3]);
        chk("done_count", 64'(n_done), 64'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/covariance_accumulator.md
Name: covariance_accumulator

Overview:
- Upstream stage of the QR/PCA path.
- Accumulates 2^N_LOG2 streamed 4-element channel vectors x and forms the sample covariance C = (1/N)·Σ x·xᵀ, a symmetric 4x4 matrix in fixed point.
- Delivers C as four 64-bit row words in the same packing the QR stage consumes on its A0..A3 inputs.
- Raises a one-cycle done pulse, which launches QR decomposition.

Parameters:
- N_LOG2, 4, log2 of samples per covariance (N=16)
- DW, 16, element width, signed Q8.8
- FRAC, 8, fractional bits of each element
- ACC_W, 40, accumulator width; must be ≥ 2·DW+N_LOG2

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a new accumulation (honoured only in IDLE)
- x_valid  in  1  x_in carries a sample
- x_in  in  64  sample vector; element i at [16i+15:16i]
- x_ready  out  1  block accepts a sample this cycle
- A0  out  64  covariance row 0; element C[0][c] at [16c+15:16c]
- A1  out  64  covariance row 1, same packing
- A2  out  64  covariance row 2, same packing
- A3  out  64  covariance row 3, same packing
- busy  out  1  high in ACCUM and SCALE
- done  out  1  one-cycle pulse; A0..A3 hold the new result

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset values: all state, accumulators, counter and A0..A3 go to zero. x_ready, busy and done = 0. State = IDLE.
- Reset mid-accumulation aborts the run. No done is produced and partial sums are discarded.
- States and transitions:
  - IDLE: x_ready=0. On start, clear the 10 accumulators and the sample counter, then go to ACCUM.
  - ACCUM: x_ready=1. A sample is accepted when x_valid & x_ready. x_valid low stalls with no state change. When the N-th sample is accepted, go to SCALE.
  - SCALE: one cycle. Register the scaled results into A0..A3, then go to DONE.
  - DONE: one cycle with done=1, then return to IDLE.
- Latency: if the last sample is accepted in cycle k, A0..A3 update at the end of k+1 and done is high in cycle k+2. A0..A3 are valid from cycle k+2.
- A0..A3 hold their last result through later IDLE/ACCUM phases. They change only at SCALE.
- Throughput: one sample per cycle.
- Arithmetic:
  - Only the 10 unique products x_i·x_j (i≤j) are computed. Each is a signed 16x16 multiply giving 32 bits (Q16.16), sign-extended into an ACC_W accumulator.
  - Result = acc >>> (FRAC+N_LOG2), arithmetic shift (truncation toward −inf).
  - The result then saturates to the signed 16-bit range [0x8000, 0x7FFF].
  - Symmetry: C[j][i] is driven from the same register as C[i][j].
- Boundary conditions:
  - start while busy or in DONE is ignored.
  - start and x_valid in the same IDLE cycle: the sample is not accepted.
  - The sample counter is N_LOG2+1 bits and never wraps within a run.

Decomposition:
- Shared package qr_pkg holds DW, FRAC, ROW_W=64, the element pack/unpack index helper, and a sat16 function (ACC_W→16 saturation). The QR stage reuses these.
- One natural sub-module: cov_mac. It holds the multiplier, accumulator, clear and enable for one matrix entry, instantiated 10 times.
- FSM, counter and output packing live in the top.

Test Plan:
- 16 samples of x=0x0000_0000_0000_0100 ([1,0,0,0]) with start, no gaps → A0=0x0000_0000_0000_0100, A1..A3=0. done exactly 2 cycles after the last accept; busy low the following cycle.
- 16 samples of x=0x0100_0100_0100_0100 → every element 0x0100 in all four rows.
- x alternating [2,1,0,0]/[−2,1,0,0] (0x0000_0000_0100_0200 / 0x0000_0000_0100_FE00), 16 samples → C00=0x0400, C11=0x0100, C01=C10=0x0000, others 0.
- Saturation case, all elements 0x7FFF → all elements 0x7FFF.
- Mixed-sign saturation case, x=[0x7FFF,0x8000,0,0] → C01=C10=0x8000, C00=C11=0x7FFF.
- x_valid toggled pseudo-randomly, plus start pulsed mid-run → result identical to the gap-free run. The mid-run start is ignored and exactly one done is produced.
- Reset asserted after 7 accepted samples → next cycle all outputs 0 and state IDLE. A new start followed by 16 samples gives a correct result with no contamination from the aborted run.
